// File: rtl/ysyx_25060170_lsu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_25060170_lsu
// Brief   : Load/store stage between EXU and WBU. Runs one data-memory access
//           at a time over a req/gnt/rvalid bus, aligns and extends load data,
//           and registers the writeback bundle for WBU.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_25060170_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [31:0]   ex_pc,
  input  logic [31:0]   ex_inst,
  input  logic [AW-1:0] ex_res,
  input  logic [DW-1:0] ex_sdata,
  input  logic [1:0]    ex_mem_op,
  input  logic [1:0]    ex_mem_size,
  input  logic          ex_mem_uns,
  input  logic [1:0]    ex_wb_ctl,
  input  logic          ex_rd_ena,
  input  logic [4:0]    ex_rd_addr,
  input  logic          flush,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rd_data,
  output logic [AW-1:0] exu_res,
  output logic [1:0]    wb_ctl,
  output logic [31:0]   inst_o,
  output logic [31:0]   pc_o,
  output logic [31:0]   ls_pc_o,
  output logic          rd_ena,
  output logic [4:0]    rd_addr,
  output logic          ls_misalign
);

  localparam logic [31:0] c_NOP      = 32'h0000_0013;
  localparam logic [1:0]  c_OP_LOAD  = 2'b01;
  localparam logic [1:0]  c_OP_STORE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;

  // Instruction held in the LSU while its bus access is in progress
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          killed_q, killed_d;
  logic [31:0]   hpc_q, hpc_d;
  logic [31:0]   hinst_q, hinst_d;
  logic [1:0]    hwb_q, hwb_d;
  logic          hrden_q, hrden_d;
  logic [4:0]    hrdaddr_q, hrdaddr_d;

  // Writeback bundle registers
  logic [AW-1:0] res_q, res_d;
  logic [1:0]    wb_q, wb_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   pc_q, pc_d;
  logic          rden_q, rden_d;
  logic [4:0]    rdaddr_q, rdaddr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic          w_accept;
  logic          w_is_mem;
  logic          w_misalign;
  logic [3:0]    w_strb;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_ld_word;
  logic [DW-1:0] w_ld_data;

  // ex_ready is forced low while reset is held so every output reads 0
  assign ex_ready   = (state_q == S_IDLE) && rst;
  assign w_accept   = ex_valid && ex_ready && !flush;
  assign w_is_mem   = (ex_mem_op == c_OP_LOAD) || (ex_mem_op == c_OP_STORE);
  assign w_misalign = ((ex_mem_size == 2'b01) && ex_res[0]) ||
                      (ex_mem_size[1] && (ex_res[1:0] != 2'b00));
  assign w_wdata    = ex_sdata << {ex_res[1:0], 3'b000};
  assign w_ld_word  = mem_rdata >> {addr_q[1:0], 3'b000};

  // Byte-lane strobes for the store, derived from size and low address bits
  always_comb begin
    w_strb = 4'b1111;
    case (ex_mem_size)
      2'b00:   w_strb = 4'b0001 << ex_res[1:0];
      2'b01:   w_strb = 4'b0011 << ex_res[1:0];
      default: w_strb = 4'b1111;
    endcase
  end

  // Sign/zero extension of the shifted load word
  always_comb begin
    w_ld_data = w_ld_word;
    case (size_q)
      2'b00:   w_ld_data = {{24{~uns_q & w_ld_word[7]}}, w_ld_word[7:0]};
      2'b01:   w_ld_data = {{16{~uns_q & w_ld_word[15]}}, w_ld_word[15:0]};
      default: w_ld_data = w_ld_word;
    endcase
  end

  // Next-state, held-access and writeback bundle logic; default bundle is a bubble
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    killed_d  = killed_q;
    hpc_d     = hpc_q;
    hinst_d   = hinst_q;
    hwb_d     = hwb_q;
    hrden_d   = hrden_q;
    hrdaddr_d = hrdaddr_q;
    res_d     = '0;
    wb_d      = 2'b00;
    inst_d    = c_NOP;
    pc_d      = '0;
    rden_d    = 1'b0;
    rdaddr_d  = '0;
    rdata_d   = '0;
    mis_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mem && !w_misalign) begin
            state_d   = S_REQ;
            addr_d    = ex_res;
            size_d    = ex_mem_size;
            uns_d     = ex_mem_uns;
            wen_d     = (ex_mem_op == c_OP_STORE);
            wdata_d   = w_wdata;
            wstrb_d   = w_strb;
            killed_d  = 1'b0;
            hpc_d     = ex_pc;
            hinst_d   = ex_inst;
            hwb_d     = ex_wb_ctl;
            hrden_d   = ex_rd_ena;
            hrdaddr_d = ex_rd_addr;
          end else begin
            // ALU-only or misaligned: bundle passes straight through
            res_d    = ex_res;
            wb_d     = ex_wb_ctl;
            inst_d   = ex_inst;
            pc_d     = ex_pc;
            rdaddr_d = ex_rd_addr;
            rden_d   = ex_rd_ena && !(w_is_mem && w_misalign);
            mis_d    = w_is_mem && w_misalign;
          end
        end
      end
      S_REQ: begin
        if (flush) killed_d = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) killed_d = 1'b1;
        if (mem_rvalid) begin
          state_d = S_IDLE;
          // A flushed access still drains the bus but leaves only a bubble
          if (!(killed_q || flush)) begin
            res_d    = addr_q;
            wb_d     = hwb_q;
            inst_d   = hinst_q;
            pc_d     = hpc_q;
            rden_d   = hrden_q;
            rdaddr_d = hrdaddr_q;
            rdata_d  = wen_q ? '0 : w_ld_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, held access and writeback registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      killed_q  <= 1'b0;
      hpc_q     <= '0;
      hinst_q   <= '0;
      hwb_q     <= '0;
      hrden_q   <= 1'b0;
      hrdaddr_q <= '0;
      res_q     <= '0;
      wb_q      <= '0;
      inst_q    <= '0;
      pc_q      <= '0;
      rden_q    <= 1'b0;
      rdaddr_q  <= '0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      killed_q  <= killed_d;
      hpc_q     <= hpc_d;
      hinst_q   <= hinst_d;
      hwb_q     <= hwb_d;
      hrden_q   <= hrden_d;
      hrdaddr_q <= hrdaddr_d;
      res_q     <= res_d;
      wb_q      <= wb_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      rden_q    <= rden_d;
      rdaddr_q  <= rdaddr_d;
      rdata_q   <= rdata_d;
      mis_q     <= mis_d;
    end
  end

  assign mem_req     = (state_q == S_REQ);
  assign mem_wen     = wen_q;
  assign mem_addr    = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign ls_valid    = (state_q != S_IDLE);
  assign ls_pc_o     = hpc_q;
  assign ls_rd_data  = rdata_q;
  assign exu_res     = res_q;
  assign wb_ctl      = wb_q;
  assign inst_o      = inst_q;
  assign pc_o        = pc_q;
  assign rd_ena      = rden_q;
  assign rd_addr     = rdaddr_q;
  assign ls_misalign = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_25060170_lsu
// Brief   : Directed self-checking bench for the load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_inst, ex_res, ex_sdata;
  logic [1:0]  ex_mem_op, ex_mem_size, ex_wb_ctl;
  logic        ex_mem_uns, ex_rd_ena;
  logic [4:0]  ex_rd_addr;
  logic        flush;
  logic        mem_req, mem_wen, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        ls_valid, rd_ena, ls_misalign;
  logic [31:0] ls_rd_data, exu_res, inst_o, pc_o, ls_pc_o;
  logic [1:0]  wb_ctl;
  logic [4:0]  rd_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25060170_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_res(ex_res), .ex_sdata(ex_sdata), .ex_mem_op(ex_mem_op),
    .ex_mem_size(ex_mem_size), .ex_mem_uns(ex_mem_uns), .ex_wb_ctl(ex_wb_ctl),
    .ex_rd_ena(ex_rd_ena), .ex_rd_addr(ex_rd_addr), .flush(flush),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ls_valid(ls_valid),
    .ls_rd_data(ls_rd_data), .exu_res(exu_res), .wb_ctl(wb_ctl),
    .inst_o(inst_o), .pc_o(pc_o), .ls_pc_o(ls_pc_o), .rd_ena(rd_ena),
    .rd_addr(rd_addr), .ls_misalign(ls_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] pc, input logic rden, input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_mem_op   = op;
    ex_mem_size = size;
    ex_mem_uns  = uns;
    ex_res      = addr;
    ex_sdata    = sdata;
    ex_pc       = pc;
    ex_inst     = 32'h0000_0003 | (32'(rd) << 7);
    ex_wb_ctl   = 2'b01;
    ex_rd_ena   = rden;
    ex_rd_addr  = rd;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; flush = 0;
    drive(2'b00, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 32'h0000_0100, 1'b1, 5'd5);
    repeat (3) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL reset_ls_valid: got %b want 0", ls_valid); end
    checks++; if ({exu_res, inst_o, pc_o} !== 96'h0) begin errors++; $display("FAIL reset_bundle: got %h want 0", {exu_res, inst_o, pc_o}); end
    checks++; if ({rd_ena, rd_addr, wb_ctl, ls_misalign} !== 9'h0) begin errors++; $display("FAIL reset_ctl: got %h want 0", {rd_ena, rd_addr, wb_ctl, ls_misalign}); end
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ex_ready: got %b want 0", ex_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL release_ex_ready: got %b want 1", ex_ready); end
    tick();
    checks++; if (exu_res !== 32'h0000_1234) begin errors++; $display("FAIL first_accept_res: got %h want 00001234", exu_res); end
    checks++; if (rd_ena !== 1'b1 || rd_addr !== 5'd5) begin errors++; $display("FAIL first_accept_rd: got %b/%0d want 1/5", rd_ena, rd_addr); end
    idle_ex();
    tick();
  endtask

  task automatic test_alu();
    drive(2'b00, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 32'h8000_0010, 1'b1, 5'd5);
    tick();
    checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL alu_ls_valid: got %b want 0", ls_valid); end
    checks++; if (exu_res !== 32'h0000_1234 || pc_o !== 32'h8000_0010) begin errors++; $display("FAIL alu_bundle: got %h/%h want 00001234/80000010", exu_res, pc_o); end
    checks++; if (rd_ena !== 1'b1 || rd_addr !== 5'd5 || wb_ctl !== 2'b01) begin errors++; $display("FAIL alu_ctl: got %b/%0d/%b want 1/5/01", rd_ena, rd_addr, wb_ctl); end
    checks++; if (ls_rd_data !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL alu_nomem: got %h/%b want 0/0", ls_rd_data, mem_req); end
    idle_ex();
    tick();
    checks++; if (rd_ena !== 1'b0 || inst_o !== 32'h0000_0013 || ls_valid !== 1'b0) begin errors++; $display("FAIL alu_bubble: got %b/%h/%b want 0/00000013/0", rd_ena, inst_o, ls_valid); end
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] exp);
    drive(2'b01, 2'b00, uns, 32'h8000_0003, 32'h0, 32'h8000_0020, 1'b1, 5'd7);
    tick();
    idle_ex();
    checks++; if (ls_valid !== 1'b1 || mem_req !== 1'b1 || ex_ready !== 1'b0) begin errors++; $display("FAIL ldb_req: got v%b r%b rdy%b want 1 1 0", ls_valid, mem_req, ex_ready); end
    checks++; if (mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin errors++; $display("FAIL ldb_addr: got %h/%b want 80000000/0", mem_addr, mem_wen); end
    checks++; if (rd_ena !== 1'b0 || inst_o !== 32'h0000_0013 || ls_pc_o !== 32'h8000_0020) begin errors++; $display("FAIL ldb_bubble: got %b/%h/%h want 0/00000013/80000020", rd_ena, inst_o, ls_pc_o); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL ldb_req_hold: got %b/%h want 1/80000000", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || ls_valid !== 1'b1) begin errors++; $display("FAIL ldb_wait: got r%b v%b want 0 1", mem_req, ls_valid); end
    tick();
    tick();
    checks++; if (ls_valid !== 1'b1 || rd_ena !== 1'b0) begin errors++; $display("FAIL ldb_busy: got v%b rd%b want 1 0", ls_valid, rd_ena); end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80AA_BBCC;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checks++; if (ls_rd_data !== exp) begin errors++; $display("FAIL ldb_data uns=%b: got %h want %h", uns, ls_rd_data, exp); end
    checks++; if (rd_ena !== 1'b1 || rd_addr !== 5'd7 || pc_o !== 32'h8000_0020) begin errors++; $display("FAIL ldb_wb: got %b/%0d/%h want 1/7/80000020", rd_ena, rd_addr, pc_o); end
    checks++; if (ls_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL ldb_done: got v%b rdy%b want 0 1", ls_valid, ex_ready); end
  endtask

  task automatic test_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    drive(2'b10, size, 1'b0, addr, sdata, 32'h8000_0040, 1'b0, 5'd0);
    tick();
    idle_ex();
    checks++; if (mem_wstrb !== exp_strb || mem_wdata !== exp_wdata) begin errors++; $display("FAIL st_lane a=%h: got %b/%h want %b/%h", addr, mem_wstrb, mem_wdata, exp_strb, exp_wdata); end
    checks++; if (mem_addr !== {addr[31:2], 2'b00} || mem_wen !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL st_req a=%h: got %h/%b/%b", addr, mem_addr, mem_wen, mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_wstrb !== exp_strb || mem_wdata !== exp_wdata || mem_wen !== 1'b1) begin errors++; $display("FAIL st_hold a=%h: got %b/%b/%h", addr, mem_req, mem_wstrb, mem_wdata); end
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++; if (ls_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL st_rvalid_in_req: got v%b r%b want 1 0", ls_valid, mem_req); end
    tick();
    mem_rvalid = 1'b0;
    checks++; if (ls_valid !== 1'b0 || ls_rd_data !== 32'h0 || rd_ena !== 1'b0) begin errors++; $display("FAIL st_done: got v%b %h rd%b want 0 0 0", ls_valid, ls_rd_data, rd_ena); end
  endtask

  task automatic test_misalign(input logic [1:0] size, input logic [31:0] addr);
    drive(2'b01, size, 1'b0, addr, 32'h0, 32'h8000_0060, 1'b1, 5'd3);
    tick();
    idle_ex();
    checks++; if (ls_misalign !== 1'b1 || rd_ena !== 1'b0) begin errors++; $display("FAIL mis_pulse a=%h: got m%b rd%b want 1 0", addr, ls_misalign, rd_ena); end
    checks++; if (mem_req !== 1'b0 || ls_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL mis_nobus a=%h: got r%b v%b rdy%b", addr, mem_req, ls_valid, ex_ready); end
    tick();
    checks++; if (ls_misalign !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_oneshot a=%h: got m%b r%b want 0 0", addr, ls_misalign, mem_req); end
  endtask

  task automatic test_flush_idle();
    drive(2'b01, 2'b10, 1'b0, 32'h8000_0008, 32'h0, 32'h8000_0080, 1'b1, 5'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_ex();
    checks++; if (mem_req !== 1'b0 || ls_valid !== 1'b0 || rd_ena !== 1'b0 || inst_o !== 32'h0000_0013) begin errors++; $display("FAIL flush_idle: got r%b v%b rd%b %h", mem_req, ls_valid, rd_ena, inst_o); end
  endtask

  task automatic test_flush_wait();
    drive(2'b01, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'h8000_00A0, 1'b1, 5'd10);
    tick();
    idle_ex();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (ls_valid !== 1'b1) begin errors++; $display("FAIL flushw_busy: got %b want 1", ls_valid); end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (rd_ena !== 1'b0 || ls_rd_data !== 32'h0) begin errors++; $display("FAIL flushw_discard: got rd%b %h want 0 0", rd_ena, ls_rd_data); end
    checks++; if (ex_ready !== 1'b1 || ls_valid !== 1'b0) begin errors++; $display("FAIL flushw_ready: got rdy%b v%b want 1 0", ex_ready, ls_valid); end
  endtask

  task automatic test_back_to_back();
    // signed half load at offset 2, immediately followed by an ALU op
    drive(2'b01, 2'b01, 1'b0, 32'h8000_0102, 32'h0, 32'h8000_00C0, 1'b1, 5'd12);
    tick();
    idle_ex();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001_7F00;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (ls_rd_data !== 32'hFFFF_8001 || rd_addr !== 5'd12 || exu_res !== 32'h8000_0102) begin errors++; $display("FAIL b2b_half: got %h/%0d/%h want ffff8001/12/80000102", ls_rd_data, rd_addr, exu_res); end
    drive(2'b11, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h8000_00C4, 1'b1, 5'd13);
    tick();
    idle_ex();
    checks++; if (exu_res !== 32'hDEAD_BEEF || rd_ena !== 1'b1 || ls_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_reserved_op: got %h rd%b v%b r%b", exu_res, rd_ena, ls_valid, mem_req); end
    // word load returns the full word
    drive(2'b01, 2'b10, 1'b1, 32'h8000_0200, 32'h0, 32'h8000_00C8, 1'b1, 5'd14);
    tick();
    idle_ex();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5_0F0F;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (ls_rd_data !== 32'hA5A5_0F0F || rd_addr !== 5'd14) begin errors++; $display("FAIL b2b_word: got %h/%0d want a5a50f0f/14", ls_rd_data, rd_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_byte(1'b0, 32'hFFFF_FF80);
    test_load_byte(1'b1, 32'h0000_0080);
    test_store(2'b01, 32'h8000_0002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
    test_store(2'b00, 32'h8000_0001, 32'h0000_00A5, 4'b0010, 32'h0000_A500);
    test_store(2'b10, 32'h8000_0010, 32'h1122_3344, 4'b1111, 32'h1122_3344);
    test_misalign(2'b10, 32'h8000_0001);
    test_misalign(2'b01, 32'h8000_0003);
    test_flush_idle();
    test_flush_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
